// File: rtl/gp_reg_file_mp.sv
// Multi-port general-purpose register file with reservation-station tag
// tracking. Each entry holds a value, a valid flag and the tag of the
// producing reservation station. Result buses retire tags, dispatch renames
// registers, flush discards all outstanding tags. Reads see same-cycle
// result-bus bypass; pending_count tracks how many entries are invalid.
module gp_reg_file_mp #(
   parameter int NUM_REGS    = 32,
   parameter int ADDR_WIDTH  = $clog2(NUM_REGS),
   parameter int DATA_WIDTH  = 32,
   parameter int READ_PORTS  = 2,
   parameter int WRITE_PORTS = 2,
   parameter int RS_ID_WIDTH = 5
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_WIDTH-1:0]         read_addr        [READ_PORTS],
   output logic                          read_value_valid [READ_PORTS],
   output logic [DATA_WIDTH-1:0]         read_value       [READ_PORTS],
   output logic [RS_ID_WIDTH-1:0]        read_rs_id       [READ_PORTS],
   input  logic                          write_enable     [WRITE_PORTS],
   input  logic [ADDR_WIDTH-1:0]         write_addr       [WRITE_PORTS],
   input  logic [DATA_WIDTH-1:0]         write_value      [WRITE_PORTS],
   input  logic [RS_ID_WIDTH-1:0]        write_rs_id      [WRITE_PORTS],
   input  logic                          update_enable,
   input  logic [ADDR_WIDTH-1:0]         update_addr,
   input  logic [RS_ID_WIDTH-1:0]        update_rs_id,
   input  logic                          flush,
   output logic [$clog2(NUM_REGS+1)-1:0] pending_count
);

   localparam int CNT_WIDTH = $clog2(NUM_REGS + 1);

   logic [DATA_WIDTH-1:0]  value_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]  value_d [NUM_REGS];
   logic [NUM_REGS-1:0]    valid_q;
   logic [NUM_REGS-1:0]    valid_d;
   logic [RS_ID_WIDTH-1:0] rs_id_q [NUM_REGS];
   logic [RS_ID_WIDTH-1:0] rs_id_d [NUM_REGS];
   logic [CNT_WIDTH-1:0]   pending_q;
   logic [CNT_WIDTH-1:0]   pending_d;

   // Per-register result-bus match and the value of the winning bus.
   logic [NUM_REGS-1:0]    wr_hit;
   logic [DATA_WIDTH-1:0]  wr_val [NUM_REGS];

   // Find, per register, the lowest-index result bus retiring its outstanding tag.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
         wr_hit[i] = 1'b0;
         wr_val[i] = '0;
         // Scan from the highest index down so the lowest matching port is assigned last and wins.
         for (int w = WRITE_PORTS - 1; w >= 0; w--) begin
            if (write_enable[w] && (write_addr[w] == ADDR_WIDTH'(i)) &&
                !valid_q[i] && (rs_id_q[i] == write_rs_id[w])) begin
               wr_hit[i] = 1'b1;
               wr_val[i] = write_value[w];
            end
         end
      end
   end

   // Operand read ports: current state plus same-cycle result-bus bypass.
   always_comb begin
      for (int r = 0; r < READ_PORTS; r++) begin
         read_value_valid[r] = 1'b1;
         read_value[r]       = '0;
         read_rs_id[r]       = '0;
         if (32'(read_addr[r]) < NUM_REGS) begin
            read_value_valid[r] = valid_q[read_addr[r]] | wr_hit[read_addr[r]];
            read_value[r]       = wr_hit[read_addr[r]] ? wr_val[read_addr[r]]
                                                       : value_q[read_addr[r]];
            read_rs_id[r]       = rs_id_q[read_addr[r]];
         end
      end
   end

   // Next state: writes retire tags, then flush or rename override valid/tag.
   always_comb begin
      pending_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         value_d[i] = wr_hit[i] ? wr_val[i] : value_q[i];
         valid_d[i] = valid_q[i] | wr_hit[i];
         rs_id_d[i] = rs_id_q[i];
         if (flush) begin
            valid_d[i] = 1'b1;
            rs_id_d[i] = '0;
         end else if (update_enable && (update_addr == ADDR_WIDTH'(i))) begin
            valid_d[i] = 1'b0;
            rs_id_d[i] = update_rs_id;
         end
         pending_d = pending_d + {{(CNT_WIDTH-1){1'b0}}, ~valid_d[i]};
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: this register file is built from flops and every entry must
         // read back valid/zero after reset, so the whole array is reset here.
         for (int i = 0; i < NUM_REGS; i++) begin
            value_q[i] <= '0;
            rs_id_q[i] <= '0;
         end
         valid_q   <= '1;
         pending_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         for (int i = 0; i < NUM_REGS; i++) begin
            value_q[i] <= value_d[i];
            rs_id_q[i] <= rs_id_d[i];
         end
         valid_q   <= valid_d;
         pending_q <= pending_d;
      end
   end

   assign pending_count = pending_q;

endmodule
